mem_seq_ctrl: RTL and testbench

// - Sequencing initiator for the single-port DFF scratch memory (rd_en/wr_en/addr, combinational read).
// - LOAD: writes a valid/ready input byte stream into consecutive addresses.
// - STREAM: reads consecutive addresses out as a valid/ready stream, e.g. weights/activations to the array.
// - Owns the memory's rd_en, wr_en, addr and data_in; consumes its data_out.

---
 rtl/mem_seq_ctrl_if.sv | 38 +++
 rtl/mem_seq_ctrl.sv | 152 +++++++++++++++
 tb/tb_mem_seq_ctrl.sv | 237 +++++++++++++++++++++++
 3 files changed

// File: rtl/mem_seq_ctrl_if.sv
// Stream and scratch-memory bundle for mem_seq_ctrl: the master modport is the
// sequencer side, the slave modport is the environment (source, sink, memory).
interface mem_seq_ctrl_if #(
  parameter int D_W = 8,
  parameter int AW  = 3
);
  logic           s_valid;
  logic           s_ready;
  logic [D_W-1:0] s_data;

  logic           m_valid;
  logic           m_ready;
  logic [D_W-1:0] m_data;

  logic           mem_wr_en;
  logic           mem_rd_en;
  logic [AW-1:0]  mem_addr;
  logic [D_W-1:0] mem_data_in;
  logic [D_W-1:0] mem_data_out;

  modport master (
    input  s_valid, s_data,
    output s_ready,
    output m_valid, m_data,
    input  m_ready,
    output mem_wr_en, mem_rd_en, mem_addr, mem_data_in,
    input  mem_data_out
  );

  modport slave (
    output s_valid, s_data,
    input  s_ready,
    input  m_valid, m_data,
    output m_ready,
    input  mem_wr_en, mem_rd_en, mem_addr, mem_data_in,
    output mem_data_out
  );
endinterface

// File: rtl/mem_seq_ctrl.sv
// Sequencer for the DFF scratch memory: LOAD writes an input stream to consecutive
// addresses, STREAM reads them out. Define MEM_SEQ_WRAP_EN for cyclic STREAM ended by stop.
module mem_seq_ctrl #(
  parameter  int D_W  = 8,
  parameter  int WORD = 8,
  localparam int AW   = $clog2(WORD)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          load_start,
  input  logic          stream_start,
  input  logic [AW-1:0] base_addr,
  input  logic [AW:0]   len,
  input  logic          stop,
  output logic          busy,
  output logic          done,
  mem_seq_ctrl_if.master bus
);

  localparam int LEN_W = AW + 1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_LOAD,
    S_STREAM,
    S_DONE
  } state_e;

  state_e             state_q, state_d;
  logic [AW-1:0]      ptr_q, ptr_d;
  logic [LEN_W-1:0]   cnt_q, cnt_d;
  logic               s_ready_q, s_ready_d;
  logic               stream_q, stream_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;

  logic [LEN_W-1:0]   len_clamped;
  logic [AW-1:0]      ptr_inc;
  logic               last_beat;

`ifdef MEM_SEQ_WRAP_EN
  logic [AW-1:0]      base_q, base_d;
  logic [LEN_W-1:0]   wlen_q, wlen_d;
`else
  logic               unused_stop;
  assign unused_stop = stop;
`endif

  assign len_clamped = (len > LEN_W'(WORD)) ? LEN_W'(WORD) : len;
  // Explicit compare keeps the wrap correct when WORD is not a power of two.
  assign ptr_inc     = (ptr_q == AW'(WORD - 1)) ? '0 : ptr_q + AW'(1);
  assign last_beat   = (cnt_q == LEN_W'(1));

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    cnt_d   = cnt_q;
`ifdef MEM_SEQ_WRAP_EN
    base_d  = base_q;
    wlen_d  = wlen_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (load_start || stream_start) begin
          ptr_d = base_addr;
          cnt_d = len_clamped;
`ifdef MEM_SEQ_WRAP_EN
          base_d = base_addr;
          wlen_d = len_clamped;
`endif
          if (len_clamped == '0) state_d = S_DONE;
          else if (load_start)   state_d = S_LOAD;
          else                   state_d = S_STREAM;
        end
      end
      S_LOAD: begin
        if (bus.s_valid) begin
          ptr_d = ptr_inc;
          cnt_d = cnt_q - LEN_W'(1);
          if (last_beat) state_d = S_DONE;
        end
      end
      S_STREAM: begin
`ifdef MEM_SEQ_WRAP_EN
        // cnt tracks position within the window; reload at the window end.
        if (bus.m_ready) begin
          if (last_beat) begin
            ptr_d = base_q;
            cnt_d = wlen_q;
          end else begin
            ptr_d = ptr_inc;
            cnt_d = cnt_q - LEN_W'(1);
          end
        end
        if (stop) state_d = S_DONE;
`else
        if (bus.m_ready) begin
          ptr_d = ptr_inc;
          cnt_d = cnt_q - LEN_W'(1);
          if (last_beat) state_d = S_DONE;
        end
`endif
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  assign s_ready_d = (state_d == S_LOAD);
  assign stream_d  = (state_d == S_STREAM);
  assign busy_d    = (state_d == S_LOAD) || (state_d == S_STREAM);
  assign done_d    = (state_d == S_DONE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= S_IDLE;
      ptr_q     <= '0;
      cnt_q     <= '0;
      s_ready_q <= 1'b0;
      stream_q  <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
`ifdef MEM_SEQ_WRAP_EN
      base_q    <= '0;
      wlen_q    <= '0;
`endif
    end else begin
      state_q   <= state_d;
      ptr_q     <= ptr_d;
      cnt_q     <= cnt_d;
      s_ready_q <= s_ready_d;
      stream_q  <= stream_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
`ifdef MEM_SEQ_WRAP_EN
      base_q    <= base_d;
      wlen_q    <= wlen_d;
`endif
    end
  end

  assign bus.s_ready     = s_ready_q;
  assign bus.mem_wr_en   = s_ready_q & bus.s_valid;
  assign bus.mem_data_in = s_ready_q ? bus.s_data : '0;
  assign bus.mem_rd_en   = stream_q;
  assign bus.m_valid     = stream_q;
  assign bus.m_data      = stream_q ? bus.mem_data_out : '0;
  assign bus.mem_addr    = busy_q ? ptr_q : '0;
  assign busy            = busy_q;
  assign done            = done_q;

endmodule

// File: tb/tb_mem_seq_ctrl.sv
// Scoreboard bench for mem_seq_ctrl with a behavioural DFF memory; works with or
// without MEM_SEQ_WRAP_EN (wrap build ends each stream with stop on its last beat).
module tb_mem_seq_ctrl;
  localparam int D_W  = 8;
  localparam int WORD = 8;
  localparam int AW   = 3;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          load_start = 1'b0;
  logic          stream_start = 1'b0;
  logic [AW-1:0] base_addr = '0;
  logic [AW:0]   len = '0;
  logic          stop = 1'b0;
  logic          busy;
  logic          done;

  int n_checks = 0;
  int n_fail   = 0;
  int done_cnt = 0;

  always #5 clk = ~clk;

  mem_seq_ctrl_if #(.D_W(D_W), .AW(AW)) bus ();

  mem_seq_ctrl #(.D_W(D_W), .WORD(WORD)) dut (
    .clk(clk), .rst(rst), .load_start(load_start), .stream_start(stream_start),
    .base_addr(base_addr), .len(len), .stop(stop), .busy(busy), .done(done),
    .bus(bus)
  );

  logic [D_W-1:0] mem [WORD];
  always @(posedge clk) if (bus.mem_wr_en) mem[bus.mem_addr] <= bus.mem_data_in;
  assign bus.mem_data_out = mem[bus.mem_addr];

  typedef struct packed {
    logic [AW-1:0]  a;
    logic [D_W-1:0] d;
  } beat_t;

  beat_t          wq[$];
  beat_t          rq[$];
  logic [D_W-1:0] ref_mem [WORD];

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  always @(negedge clk) begin
    beat_t e;
    if (done) done_cnt++;
    if (bus.mem_wr_en) begin
      if (wq.size() == 0) chk("wr_unexp", 32'(wq.size()), 32'd1);
      else begin
        e = wq.pop_front();
        chk("wr_addr", 32'(bus.mem_addr), 32'(e.a));
        chk("wr_data", 32'(bus.mem_data_in), 32'(e.d));
      end
    end
    if (bus.m_valid && bus.m_ready) begin
      if (rq.size() == 0) chk("rd_unexp", 32'(rq.size()), 32'd1);
      else begin
        e = rq.pop_front();
        chk("rd_addr", 32'(bus.mem_addr), 32'(e.a));
        chk("rd_data", 32'(bus.m_data), 32'(e.d));
        chk("rd_en", 32'(bus.mem_rd_en), 32'd1);
      end
    end
  end

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic run_load(input logic [AW-1:0] base, input logic [AW:0] l, input int n_exp,
                          input int n_drive, input int gap_at, input bit seq,
                          input bit both, input bit poke);
    int    d0 = done_cnt;
    beat_t e;
    tick();
    load_start = 1'b1; stream_start = both; base_addr = base; len = l;
    tick();
    load_start = 1'b0; stream_start = 1'b0;
    for (int i = 0; i < n_drive; i++) begin
      if (i == gap_at) begin
        bus.s_valid = 1'b0;
        tick();
      end
      stream_start = poke && (i == 1);
      bus.s_valid  = 1'b1;
      bus.s_data   = seq ? D_W'(8'h10 + i) : D_W'($urandom);
      if (i < n_exp) begin
        e.a = AW'(int'(base) + i);
        e.d = bus.s_data;
        ref_mem[e.a] = e.d;
        wq.push_back(e);
      end
      tick();
    end
    bus.s_valid = 1'b0; stream_start = 1'b0;
    repeat (2) tick();
    chk("wr_left", 32'(wq.size()), 32'd0);
    chk("wr_done", 32'(done_cnt - d0), 32'd1);
  endtask

  task automatic run_stream(input logic [AW-1:0] base, input logic [AW:0] l, input int n_beats,
                            input int hold_beat, input int hold_cyc, input int stop_at);
    int    d0 = done_cnt;
    int    stall = 0;
    int    budget = 0;
    int    lc = (int'(l) > WORD) ? WORD : int'(l);
    beat_t e;
    for (int i = 0; i < n_beats; i++) begin
      e.a = AW'(int'(base) + (i % lc));
      e.d = ref_mem[e.a];
      rq.push_back(e);
    end
    tick();
    stream_start = 1'b1; base_addr = base; len = l;
    tick();
    stream_start = 1'b0;
    while (rq.size() != 0 && budget < 64) begin
      if ((n_beats - rq.size()) == hold_beat && stall < hold_cyc) begin
        bus.m_ready = 1'b0; stop = 1'b0; stall++;
        @(negedge clk);
        chk("stall_data", 32'(bus.m_data), 32'(ref_mem[AW'(int'(base) + hold_beat)]));
        chk("stall_addr", 32'(bus.mem_addr), 32'(AW'(int'(base) + hold_beat)));
        tick();
      end else begin
        bus.m_ready = 1'b1;
        stop = (rq.size() <= stop_at);
        tick();
      end
      budget++;
    end
    stop = 1'b0; bus.m_ready = 1'b1;
    chk("rd_left", 32'(rq.size()), 32'd0);
    rq.delete();
    repeat (2) tick();
    chk("rd_done", 32'(done_cnt - d0), 32'd1);
  endtask

  initial begin
    int d0;
    beat_t e;
    bus.s_valid = 1'b0; bus.s_data = '0; bus.m_ready = 1'b1;
    #2;
    chk("rst_s_ready", 32'(bus.s_ready), 32'd0);
    chk("rst_m_valid", 32'(bus.m_valid), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_addr", 32'(bus.mem_addr), 32'd0);
    @(negedge clk); @(negedge clk); rst = 1'b0;
    tick();

    run_load(3'd0, 4'd8, 8, 8, -1, 1'b1, 1'b0, 1'b0);
    run_stream(3'd0, 4'd8, 8, -1, 0, 1);
    run_stream(3'd0, 4'd3, 3, 1, 2, 1);

    run_load(3'd6, 4'd4, 4, 4, 2, 1'b0, 1'b0, 1'b0);
    run_stream(3'd6, 4'd4, 4, -1, 0, 1);

    d0 = done_cnt;
    tick();
    load_start = 1'b1; len = 4'd0; base_addr = 3'd5;
    tick();
    load_start = 1'b0;
    @(negedge clk);
    chk("len0_done", 32'(done), 32'd1);
    chk("len0_busy", 32'(busy), 32'd0);
    tick();
    stream_start = 1'b1;
    tick();
    stream_start = 1'b0;
    @(negedge clk);
    chk("len0s_done", 32'(done), 32'd1);
    chk("len0s_valid", 32'(bus.m_valid), 32'd0);
    tick();
    chk("len0_pulses", 32'(done_cnt - d0), 32'd2);

    run_load(3'd3, 4'd12, 8, 10, -1, 1'b0, 1'b0, 1'b0);
    run_stream(3'd0, 4'd12, 8, -1, 0, 1);

    run_load(3'd1, 4'd3, 3, 3, -1, 1'b0, 1'b1, 1'b0);
    run_load(3'd4, 4'd4, 4, 4, -1, 1'b0, 1'b0, 1'b1);
    run_stream(3'd0, 4'd8, 8, -1, 0, 1);

`ifdef MEM_SEQ_WRAP_EN
    run_stream(3'd2, 4'd2, 6, -1, 0, 1);
`else
    run_stream(3'd0, 4'd3, 3, -1, 0, 3);
`endif

    d0 = done_cnt;
    tick();
    load_start = 1'b1; base_addr = 3'd0; len = 4'd8;
    tick();
    load_start = 1'b0;
    for (int i = 0; i < 2; i++) begin
      bus.s_valid = 1'b1; bus.s_data = D_W'(8'hA0 + i);
      e.a = AW'(i); e.d = bus.s_data; ref_mem[e.a] = e.d; wq.push_back(e);
      tick();
    end
    bus.s_valid = 1'b1; bus.s_data = 8'hA2;
    #1 rst = 1'b1;
    #1;
    chk("mid_s_ready", 32'(bus.s_ready), 32'd0);
    chk("mid_wr_en", 32'(bus.mem_wr_en), 32'd0);
    chk("mid_addr", 32'(bus.mem_addr), 32'd0);
    chk("mid_data_in", 32'(bus.mem_data_in), 32'd0);
    chk("mid_busy", 32'(busy), 32'd0);
    chk("mid_done", 32'(done), 32'd0);
    chk("mid_wr_left", 32'(wq.size()), 32'd0);
    bus.s_valid = 1'b0;
    @(negedge clk); rst = 1'b0;
    tick(); tick();
    chk("post_busy", 32'(busy), 32'd0);
    chk("post_s_ready", 32'(bus.s_ready), 32'd0);
    chk("post_no_done", 32'(done_cnt - d0), 32'd0);

    run_stream(3'd0, 4'd2, 2, -1, 0, 1);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

endmodule
